// File: rtl/d_cache_pkg.sv
// Shared definitions for the PLRU n-way data cache: FSM encoding, size
// codes and the store byte-lane helpers.
package d_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_RF   = 3'd2,
        S_UC   = 3'd3,
        S_RESP = 3'd4
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Byte-lane enables for a store of the given size at the given low address bits.
    function automatic logic [3:0] wr_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replace the enabled byte lanes of old with the matching lanes of wdata.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = m[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: picks a victim (lowest invalid way first,
// otherwise walks the tree) and computes the bits after touching a way.
// Node n has children 2n+1 (lower half) and 2n+2 (upper half).
module plru_tree #(
    parameter int WAYS = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  bits_i,
    input  logic [WAYS-1:0]  valid_i,
    input  logic [WAY_W-1:0] acc_way_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [WAYS-2:0]  bits_o
);

    function automatic logic [WAY_W-1:0] next_node(input logic [WAY_W-1:0] n, input logic b);
        return WAY_W'(2 * int'(n) + 1 + int'(b));
    endfunction

    // Victim: follow node bits from the root, then let any invalid way override.
    always_comb begin
        logic [WAY_W-1:0] node;
        victim_o = '0;
        node     = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_o[WAY_W-1-l] = bits_i[node];
            node = next_node(node, bits_i[node]);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WAY_W'(w);
        end
    end

    // Touch: every node on the path points away from the accessed way.
    always_comb begin
        logic [WAY_W-1:0] node;
        logic             b;
        bits_o = bits_i;
        node   = '0;
        for (int l = 0; l < WAY_W; l++) begin
            b            = acc_way_i[WAY_W-1-l];
            bits_o[node] = ~b;
            node         = next_node(node, b);
        end
    end

endmodule

// File: rtl/d_cache_plru_nway.sv
// Write-back, write-allocate L1 data cache with tree PLRU replacement,
// multi-word lines moved as single-word beats, and an uncached bypass.
// One CPU request in flight at a time.
module d_cache_plru_nway
    import d_cache_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAYS         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    input  logic        cpu_data_uncached,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);

    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int WORD_W     = OFFSET_WIDTH - 2;
    localparam int LINE_WORDS = 1 << WORD_W;
    localparam int TAG_W      = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W      = $clog2(WAYS);

    state_e state_q, state_d;
    logic [WORD_W-1:0] cnt_q;
    logic              wait_q;
    logic [31:0]       addr_q, wdata_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        mask_q;
    logic [WAY_W-1:0]  vway_q;

    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];

    logic [TAG_W-1:0]       cpu_tag, lat_tag;
    logic [INDEX_WIDTH-1:0] cpu_idx, idx_q, plru_idx;
    logic [WORD_W-1:0]      cpu_word, word_q;
    logic [3:0]             cpu_mask;

    assign cpu_tag  = cpu_data_addr[31 -: TAG_W];
    assign cpu_idx  = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_word = cpu_data_addr[2 +: WORD_W];
    assign cpu_mask = wr_mask(cpu_data_size, cpu_data_addr[1:0]);
    assign lat_tag  = addr_q[31 -: TAG_W];
    assign idx_q    = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign word_q   = addr_q[2 +: WORD_W];

    logic             hit;
    logic [WAY_W-1:0] hit_way, victim, acc_way;
    logic [WAYS-2:0]  plru_upd;

    // Tag compare across all ways of the requested set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cpu_idx][w] && tag_q[w][cpu_idx] == cpu_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    logic [31:0]      hit_word, fill_word, wb_word;
    logic [TAG_W-1:0] wb_tag;
    assign hit_word  = data_q[hit_way][cpu_idx][cpu_word];
    assign fill_word = data_q[vway_q][idx_q][word_q];
    assign wb_word   = data_q[vway_q][idx_q][cnt_q];
    assign wb_tag    = tag_q[vway_q][idx_q];

    // Victim choice looks at the incoming set; the fill touch uses the latched set.
    assign plru_idx = (state_q == S_IDLE) ? cpu_idx : idx_q;
    assign acc_way  = (state_q == S_RESP) ? vway_q : hit_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i   (plru_q[plru_idx]),
        .valid_i  (valid_q[cpu_idx]),
        .acc_way_i(acc_way),
        .victim_o (victim),
        .bits_o   (plru_upd)
    );

    logic idle, lookup, hit_acc, miss_acc, uc_acc, mem_req, beat_done, last_beat, victim_dirty;
    assign idle         = (state_q == S_IDLE);
    assign lookup       = idle && cpu_data_req && !cpu_data_uncached;
    assign hit_acc      = lookup && hit;
    assign miss_acc     = lookup && !hit;
    assign uc_acc       = idle && cpu_data_req && cpu_data_uncached;
    assign mem_req      = (state_q inside {S_WB, S_RF, S_UC}) && !wait_q;
    // A beat ends on data_ok, either after an earlier accept or together with it.
    assign beat_done    = cache_data_data_ok && (wait_q || (mem_req && cache_data_addr_ok));
    assign last_beat    = beat_done && (cnt_q == WORD_W'(LINE_WORDS - 1));
    assign victim_dirty = valid_q[cpu_idx][victim] && dirty_q[cpu_idx][victim];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (uc_acc)        state_d = S_UC;
                else if (miss_acc) state_d = victim_dirty ? S_WB : S_RF;
            end
            S_WB:    if (last_beat) state_d = S_RF;
            S_RF:    if (last_beat) state_d = S_RESP;
            S_UC:    if (beat_done) state_d = S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; everything is forced low while reset is held.
    always_comb begin
        cpu_data_rdata   = '0;
        cpu_data_addr_ok = 1'b0;
        cpu_data_data_ok = 1'b0;
        cache_data_req   = 1'b0;
        cache_data_wr    = 1'b0;
        cache_data_size  = 2'd0;
        cache_data_addr  = '0;
        cache_data_wdata = '0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    cpu_data_addr_ok = cpu_data_req;
                    if (hit_acc) begin
                        cpu_data_data_ok = 1'b1;
                        cpu_data_rdata   = hit_word;
                    end
                end
                S_WB: begin
                    cache_data_req   = mem_req;
                    cache_data_wr    = 1'b1;
                    cache_data_size  = SZ_WORD;
                    cache_data_addr  = {wb_tag, idx_q, cnt_q, 2'b00};
                    cache_data_wdata = wb_word;
                end
                S_RF: begin
                    cache_data_req  = mem_req;
                    cache_data_size = SZ_WORD;
                    cache_data_addr = {lat_tag, idx_q, cnt_q, 2'b00};
                end
                S_UC: begin
                    cache_data_req   = mem_req;
                    cache_data_wr    = wr_q;
                    cache_data_size  = size_q;
                    cache_data_addr  = addr_q;
                    cache_data_wdata = wdata_q;
                    cpu_data_data_ok = beat_done;
                    cpu_data_rdata   = beat_done ? cache_data_rdata : 32'd0;
                end
                S_RESP: begin
                    cpu_data_data_ok = 1'b1;
                    cpu_data_rdata   = fill_word;
                end
                default: ;
            endcase
        end
    end

    // Request latch, beat counter and handshake phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            mask_q  <= 4'd0;
            vway_q  <= '0;
        end else begin
            if (miss_acc || uc_acc) begin
                addr_q  <= cpu_data_addr;
                wdata_q <= cpu_data_wdata;
                wr_q    <= cpu_data_wr;
                size_q  <= cpu_data_size;
                mask_q  <= cpu_mask;
                vway_q  <= victim;
            end
            if (beat_done) begin
                wait_q <= 1'b0;
                if (state_q != S_UC) cnt_q <= cnt_q + WORD_W'(1);
            end else if (mem_req && cache_data_addr_ok) begin
                wait_q <= 1'b1;
            end
        end
    end

    // Valid, dirty and PLRU bookkeeping; the victim is invalidated as soon as it is chosen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (hit_acc) begin
                plru_q[cpu_idx] <= plru_upd;
                if (cpu_data_wr) dirty_q[cpu_idx][hit_way] <= 1'b1;
            end
            if (miss_acc) begin
                valid_q[cpu_idx][victim] <= 1'b0;
                dirty_q[cpu_idx][victim] <= 1'b0;
            end
            if (state_q == S_RF && last_beat) begin
                valid_q[idx_q][vway_q] <= 1'b1;
                dirty_q[idx_q][vway_q] <= 1'b0;
            end
            if (state_q == S_RESP) begin
                plru_q[idx_q] <= plru_upd;
                if (wr_q) dirty_q[idx_q][vway_q] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: store hits, refill beats and the deferred store after a fill.
    always_ff @(posedge clk) begin
        if (hit_acc && cpu_data_wr)
            data_q[hit_way][cpu_idx][cpu_word] <= merge(hit_word, cpu_data_wdata, cpu_mask);
        if (state_q == S_RF && beat_done) begin
            data_q[vway_q][idx_q][cnt_q] <= cache_data_rdata;
            if (last_beat) tag_q[vway_q][idx_q] <= lat_tag;
        end
        if (state_q == S_RESP && wr_q)
            data_q[vway_q][idx_q][word_q] <= merge(fill_word, wdata_q, mask_q);
    end

endmodule

// File: tb/tb_d_cache_plru_nway.sv
// Table-driven bench for d_cache_plru_nway: CPU ops from a vector table,
// a memory slave that logs every transfer, and a scoreboard on cpu data_ok.
module tb_d_cache_plru_nway;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_data_req = 1'b0, cpu_data_wr = 1'b0, cpu_data_uncached = 1'b0;
    logic [1:0]  cpu_data_size = 2'd0;
    logic [31:0] cpu_data_addr = '0, cpu_data_wdata = '0;
    logic [31:0] cpu_data_rdata;
    logic        cpu_data_addr_ok, cpu_data_data_ok;
    logic        cache_data_req, cache_data_wr;
    logic [1:0]  cache_data_size;
    logic [31:0] cache_data_addr, cache_data_wdata;
    logic [31:0] cache_data_rdata = '0;
    logic        cache_data_addr_ok = 1'b0, cache_data_data_ok = 1'b0;

    always #5 clk = ~clk;

    d_cache_plru_nway dut (
        .clk(clk), .rst(rst),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
        .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
        .cpu_data_uncached(cpu_data_uncached), .cpu_data_rdata(cpu_data_rdata),
        .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
        .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
        .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
        .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
        .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: DUT event did not arrive in time", name);
    endtask

    // ---------------- memory slave ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic [31:0] mem [logic [31:0]];
    xfer_t       xlog[$];
    xfer_t       px;
    bit          fast = 1'b0;
    bit          pend = 1'b0;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    // Unwritten words read back as their own address. Responses are set up on
    // the falling edge so the DUT sees them at the next rising edge.
    always begin
        @(negedge clk);
        cache_data_addr_ok = 1'b0;
        cache_data_data_ok = 1'b0;
        if (!rst) begin
            pend = 1'b0;
        end else if (pend) begin
            xlog.push_back(px);
            if (px.wr) mem[px.addr] = px.wdata;
            else cache_data_rdata = rd_mem(px.addr);
            cache_data_data_ok = 1'b1;
            pend = 1'b0;
        end else if (cache_data_req) begin
            px = '{cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata};
            cache_data_addr_ok = 1'b1;
            if (fast) begin
                xlog.push_back(px);
                if (px.wr) mem[px.addr] = px.wdata;
                else cache_data_rdata = rd_mem(px.addr);
                cache_data_data_ok = 1'b1;
            end else begin
                pend = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rd;
        logic        chk_rd;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always begin
        @(negedge clk);
        #1;
        if (rst && cpu_data_data_ok) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected cpu data_ok: got 1 expected 0");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_rd) chk({mon_e.name, " rdata"}, cpu_data_rdata, mon_e.rd);
            end
        end
    end

    // ---------------- CPU side ----------------
    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        unc;
        logic [31:0] rd;
        logic        hit;
        int          nx;
        int          nwb;
        logic [31:0] wbase;
        logic [31:0] rbase;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                                input logic [31:0] wd, input logic unc, input logic [31:0] rd,
                                input logic hit, input int nx, input int nwb,
                                input logic [31:0] wbase, input logic [31:0] rbase);
        vec_t v;
        v = '{wr, sz, addr, wd, unc, rd, hit, nx, nwb, wbase, rbase};
        return v;
    endfunction

    task automatic cpu_op(input vec_t v, input string nm, output int lat, output logic hit_now);
        bit got;
        @(posedge clk);
        #1;
        cpu_data_req      = 1'b1;
        cpu_data_wr       = v.wr;
        cpu_data_size     = v.sz;
        cpu_data_addr     = v.addr;
        cpu_data_wdata    = v.wd;
        cpu_data_uncached = v.unc;
        sb_q.push_back('{v.rd, !v.wr, nm});
        @(negedge clk);
        #1;
        chk({nm, " addr_ok"}, 32'(cpu_data_addr_ok), 32'd1);
        hit_now = cpu_data_data_ok;
        @(posedge clk);
        #1;
        cpu_data_req = 1'b0;
        lat = 0;
        if (!hit_now) begin
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk);
                #1;
                lat++;
                if (cpu_data_data_ok) got = 1'b1;
            end
            if (!got) fail({nm, " data_ok"});
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm, output int lat);
        int          base;
        logic        hit_now;
        xfer_t       x;
        logic [31:0] ea;
        base = xlog.size();
        cpu_op(v, nm, lat, hit_now);
        chk({nm, " hit"}, 32'(hit_now), 32'(v.hit));
        chk({nm, " nxfer"}, 32'(xlog.size() - base), 32'(v.nx));
        for (int j = 0; j < v.nx && base + j < xlog.size(); j++) begin
            x  = xlog[base + j];
            ea = (j < v.nwb) ? v.wbase + 32'(4 * j) : v.rbase + 32'(4 * (j - v.nwb));
            chk($sformatf("%s xfer%0d addr", nm, j), x.addr, ea);
            chk($sformatf("%s xfer%0d wr", nm, j), 32'(x.wr), 32'(j < v.nwb));
            if (v.unc) chk($sformatf("%s xfer%0d size", nm, j), 32'(x.size), 32'(v.sz));
            else       chk($sformatf("%s xfer%0d size", nm, j), 32'(x.size), 32'd2);
        end
    endtask

    vec_t vecs[20];
    int   lat;

    initial begin
        // wr sz addr wdata unc rdata hit nx nwb wbase rbase
        vecs[0]  = mk(0, 2, 32'h0000_1004, 0,            0, 32'h0000_1004, 0, 4, 0, 0, 32'h0000_1000);
        vecs[1]  = mk(0, 2, 32'h0000_1004, 0,            0, 32'h0000_1004, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h0000_1005, 32'h0000_AB00, 0, 0,            1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 2, 32'h0000_1004, 0,            0, 32'h0000_AB04, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 32'h0000_1008, 32'hFFFF_BEEF, 0, 0,            1, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 32'h0000_100A, 32'h1234_0000, 0, 0,            1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 2, 32'h0000_1008, 0,            0, 32'h1234_BEEF, 1, 0, 0, 0, 0);
        vecs[7]  = mk(0, 2, 32'h0000_0000, 0,            0, 32'h0000_0000, 0, 4, 0, 0, 32'h0000_0000);
        vecs[8]  = mk(0, 2, 32'h0000_0804, 0,            0, 32'h0000_0804, 0, 4, 0, 0, 32'h0000_0800);
        vecs[9]  = mk(0, 2, 32'h0000_1808, 0,            0, 32'h0000_1808, 0, 4, 0, 0, 32'h0000_1800);
        vecs[10] = mk(0, 2, 32'h0000_100C, 0,            0, 32'h0000_100C, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 2, 32'h0000_0000, 0,            0, 32'h0000_0000, 1, 0, 0, 0, 0);
        vecs[12] = mk(0, 2, 32'h0000_0800, 0,            0, 32'h0000_0800, 1, 0, 0, 0, 0);
        vecs[13] = mk(0, 2, 32'h0000_1800, 0,            0, 32'h0000_1800, 1, 0, 0, 0, 0);
        vecs[14] = mk(0, 2, 32'h0000_2000, 0,            0, 32'h0000_2000, 0, 8, 4, 32'h0000_1000, 32'h0000_2000);
        vecs[15] = mk(0, 2, 32'h0000_1004, 0,            0, 32'h0000_AB04, 0, 4, 0, 0, 32'h0000_1000);
        vecs[16] = mk(1, 2, 32'hBFAF_F000, 32'h1234_5678, 1, 0,            0, 1, 1, 32'hBFAF_F000, 0);
        vecs[17] = mk(0, 2, 32'h0000_1004, 0,            0, 32'h0000_AB04, 1, 0, 0, 0, 0);
        vecs[18] = mk(0, 2, 32'hBFAF_F000, 0,            1, 32'h1234_5678, 0, 1, 0, 0, 32'hBFAF_F000);
        vecs[19] = mk(0, 2, 32'h0000_2008, 0,            0, 32'h0000_2008, 1, 0, 0, 0, 0);

        // Outputs stay low under reset even with a request presented.
        repeat (2) @(posedge clk);
        #1;
        cpu_data_req  = 1'b1;
        cpu_data_addr = 32'h0000_1004;
        #1;
        chk("reset addr_ok", 32'(cpu_data_addr_ok), 32'd0);
        chk("reset data_ok", 32'(cpu_data_data_ok), 32'd0);
        chk("reset mem req", 32'(cache_data_req), 32'd0);
        chk("reset mem addr", cache_data_addr, 32'd0);
        cpu_data_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i), lat);
            if (i == 0) chk("v0 slow refill latency", 32'(lat), 32'd9);
        end

        // The dirty line written back must carry the merged store data.
        chk("wb word 0x1004", rd_mem(32'h0000_1004), 32'h0000_AB04);
        chk("wb word 0x1008", rd_mem(32'h0000_1008), 32'h1234_BEEF);
        chk("uc store data", rd_mem(32'hBFAF_F000), 32'h1234_5678);

        // Memory accepting and completing in one cycle: four beats plus the response cycle.
        fast = 1'b1;
        run_vec(mk(0, 2, 32'h0000_3004, 0, 0, 32'h0000_3004, 0, 4, 0, 0, 32'h0000_3000), "fast", lat);
        chk("fast refill latency", 32'(lat), 32'd5);
        run_vec(mk(0, 2, 32'h0000_300C, 0, 0, 32'h0000_300C, 1, 0, 0, 0, 0), "fast hit", lat);
        fast = 1'b0;

        // Reset in the middle of a refill.
        @(posedge clk);
        #1;
        cpu_data_req  = 1'b1;
        cpu_data_wr   = 1'b0;
        cpu_data_size = 2'd2;
        cpu_data_addr = 32'h0000_4004;
        cpu_data_uncached = 1'b0;
        @(negedge clk);
        #1;
        chk("midrf addr_ok", 32'(cpu_data_addr_ok), 32'd1);
        @(posedge clk);
        #1;
        cpu_data_req = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrf rst mem req", 32'(cache_data_req), 32'd0);
        chk("midrf rst mem addr", cache_data_addr, 32'd0);
        chk("midrf rst data_ok", 32'(cpu_data_data_ok), 32'd0);
        chk("midrf rst rdata", cpu_data_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        run_vec(mk(0, 2, 32'h0000_4004, 0, 0, 32'h0000_4004, 0, 4, 0, 0, 32'h0000_4000), "post-rst", lat);
        run_vec(mk(0, 2, 32'h0000_1004, 0, 0, 32'h0000_AB04, 0, 4, 0, 0, 32'h0000_1000), "post-rst 1004", lat);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/d_cache_plru_nway.md
Name: d_cache_plru_nway

Overview:
- Next-generation write-back, write-allocate L1 data cache between the MIPS core data port and the AXI bridge. Both sides use the sram-like req/addr_ok/data_ok interface.
- Generalised over the previous cache in three ways: parametrised associativity with a tree pseudo-LRU; multi-word lines, refilled and written back as sequences of single-word transfers; an uncached bypass path.
- Only one CPU request is outstanding at a time.

Parameters:
- INDEX_WIDTH, 7, set index bits; sets = 2^INDEX_WIDTH.
- OFFSET_WIDTH, 4, byte offset bits; line = 2^OFFSET_WIDTH bytes; LINE_WORDS = 2^(OFFSET_WIDTH-2); legal range 2..6.
- WAYS, 4, associativity; power of two, 2..8; PLRU uses WAYS-1 bits per set.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
- cpu_data_req  in  1  CPU request valid.
- cpu_data_wr  in  1  1 = store.
- cpu_data_size  in  2  0 = byte, 1 = half, 2 = word.
- cpu_data_addr  in  32  byte address.
- cpu_data_wdata  in  32  store data, byte lanes aligned to address.
- cpu_data_uncached  in  1  1 = bypass the arrays.
- cpu_data_rdata  out  32  load data; valid while cpu_data_data_ok=1.
- cpu_data_addr_ok  out  1  request accepted.
- cpu_data_data_ok  out  1  request completed.
- cache_data_req  out  1  memory request valid.
- cache_data_wr  out  1  memory write.
- cache_data_size  out  2  transfer size.
- cache_data_addr  out  32  memory address.
- cache_data_wdata  out  32  memory write data.
- cache_data_rdata  in  32  memory read data.
- cache_data_addr_ok  in  1  memory accepted request.
- cache_data_data_ok  in  1  memory transfer done.

Behaviour:
- Reset (rst=0):
  - state=IDLE; word counter=0.
  - All valid, dirty and PLRU bits cleared. Tag and data arrays are not reset.
  - All outputs 0.
  - Reset mid-refill or mid-writeback abandons the transfer; the partially filled line stays invalid.
- Address split: offset = addr[OFFSET_WIDTH-1:0]; word = addr[OFFSET_WIDTH-1:2]; index = next INDEX_WIDTH bits; tag = the rest.
- Store write mask:
  - size 0: one byte selected by addr[1:0].
  - size 1: 4'b0011 if addr[1]=0, else 4'b1100.
  - size 2: 4'b1111.
  - Merge: new = old & ~mask | wdata & mask.
- Hit (IDLE, req=1, cached, some valid way tag-equal):
  - addr_ok=data_ok=1 in the same cycle.
  - Load: rdata = that word, combinational.
  - Store: merged word written at the edge; dirty set.
  - PLRU path updated.
- Miss or uncached (IDLE, req=1):
  - addr_ok=1 that cycle, data_ok=0.
  - Latch addr, wr, size, wdata, mask, victim way.
  - Core must not issue a new req before data_ok.
- Victim: lowest-numbered invalid way; if none, walk the PLRU tree. At each node, bit=0 selects the lower half and bit=1 the upper half.
- PLRU update: on every hit or fill, each node on the path to the accessed way is set to point away from it (accessed in lower half -> node=1).
- FSM states: IDLE, WB, RF, UC, RESP.
  - IDLE -> WB: cached miss with valid and dirty victim.
  - IDLE -> RF: cached miss with clean or invalid victim.
  - IDLE -> UC: uncached request.
  - WB -> RF: after LINE_WORDS write transfers.
  - RF -> RESP: after LINE_WORDS read transfers.
  - UC -> IDLE: on data_ok; cpu_data_data_ok pulses that cycle and rdata = cache_data_rdata.
  - RESP -> IDLE: one cycle.
- WB state:
  - wr=1, size=2.
  - addr = {victim tag, index, counter, 2'b00}; wdata = victim word[counter].
- RF state:
  - wr=0, size=2.
  - addr = {latched tag, index, counter, 2'b00}.
  - Each data_ok writes cache_data_rdata into victim word[counter].
  - The last word also writes tag, valid=1, dirty=0.
- UC state: one transfer with the latched wr, size, addr and wdata. The arrays are untouched.
- RESP state:
  - data_ok=1.
  - Load: rdata = filled word.
  - Store: merge into the filled word and set dirty.
  - PLRU updated.
- Per-transfer handshake:
  - req held high until addr_ok, then low until data_ok.
  - addr_ok and data_ok may arrive in the same cycle; this completes the transfer.
  - On data_ok, counter increments and wraps to 0 after LINE_WORDS-1.
  - The next transfer's req may assert the cycle after data_ok.
- cpu_data_addr_ok is never asserted outside IDLE.

Decomposition:
- Shared package/header d_cache_pkg:
  - FSM state encodings.
  - Size codes.
  - Write-mask function and byte-merge function.
- Sub-module plru_tree (parameter WAYS):
  - Inputs: WAYS-1 bit vector, valid vector, accessed way.
  - Outputs: victim way, updated bit vector.
  - Purely combinational; instantiated once in the cache.

Test Plan:
- Cold load 0x0000_1004 (cached), memory returns word = addr:
  - 4 reads at 0x1000/04/08/0C, then data_ok with rdata=0x0000_1004.
  - Repeat load hits the same cycle with no cache_data_req.
- Store byte 0xAB at 0x0000_1005 (size 0) after that fill:
  - Hit, mask 4'b0010.
  - Load 0x1004 returns 0x0000_AB04.
- Fill set 0 with 4 distinct tags, access ways 0,1,2,3, then miss a 5th tag:
  - Victim way 0.
  - Dirty way 0 written back as 4 writes before the 4 refill reads.
- Uncached store 0xBFAF_F000=0x1234_5678:
  - One write transfer with size 2.
  - Subsequent cached lookup of that index unchanged.
- Memory returns addr_ok and data_ok in the same cycle on every beat: a refill completes in 4 beats, LINE_WORDS+1 cycles total.
- Assert rst=0 mid-refill:
  - Outputs 0 immediately.
  - After release, the same load misses again and refills.
